// File: rtl/apb_master_pkg.sv
// Shared constants for apb_master: FSM state encoding and APB slave select codes.
package apb_master_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   localparam logic [1:0] PSEL_GPIO = 2'b01;
   localparam logic [1:0] PSEL_UART = 2'b10;

endpackage

// File: rtl/apb_master_if.sv
// APB bus bundle between apb_master (requester) and the GPIO/UART slaves.
interface apb_master_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned SEL_W  = 2
);

   logic [ADDR_W-1:0] pAdd;
   logic [DATA_W-1:0] pwData;
   logic [SEL_W-1:0]  psel;
   logic              pen;
   logic              pwr;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      output pAdd, pwData, psel, pen, pwr,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  pAdd, pwData, psel, pen, pwr,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/apb_master_wait_timer.sv
// ACCESS-phase wait counter; expired marks the LIMIT-th consecutive enabled cycle.
module apb_wait_timer #(
   parameter int unsigned LIMIT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// APB requester: one command -> SETUP+ACCESS transfer -> one-cycle response.
// Optional ACCESS timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_master
   import apb_master_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned SEL_W          = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_wr,
   input  logic [SEL_W-1:0]  cmd_psel,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   apb_master_if.master      bus
);

   logic [1:0] state;
   logic       expired;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_master: TIMEOUT_CYCLES must be >= 1");
   end

`ifdef APB_TIMEOUT_EN
   apb_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state != ST_ACCESS),
      .enable  (state == ST_ACCESS),
      .expired (expired)
   );
`else
   assign expired = 1'b0;
`endif

   assign cmd_ready = (state == ST_IDLE);

   // The bus registers double as the command latch: they hold the accepted
   // command stable from SETUP through the end of ACCESS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         bus.pAdd    <= '0;
         bus.pwData  <= '0;
         bus.psel    <= '0;
         bus.pen     <= 1'b0;
         bus.pwr     <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  if ($countones(cmd_psel) == 1) begin
                     state      <= ST_SETUP;
                     bus.psel   <= cmd_psel;
                     bus.pAdd   <= cmd_addr;
                     bus.pwr    <= cmd_wr;
                     bus.pwData <= cmd_wr ? cmd_wdata : '0;
                  end else begin
                     rsp_valid   <= 1'b1;
                     rsp_err     <= 1'b1;
                     rsp_timeout <= 1'b0;
                     rsp_rdata   <= '0;
                  end
               end
            end
            ST_SETUP: begin
               bus.pen <= 1'b1;
               state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // pready on the final counted cycle takes priority over the abort.
               if (bus.pready) begin
                  state       <= ST_IDLE;
                  bus.psel    <= '0;
                  bus.pen     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_err     <= bus.pslverr;
                  rsp_timeout <= 1'b0;
                  rsp_rdata   <= bus.pwr ? '0 : bus.prdata;
               end else if (expired) begin
                  state       <= ST_IDLE;
                  bus.psel    <= '0;
                  bus.pen     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_rdata   <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: vector table, corner sequences and random traffic.
module tb_apb_master;
   import apb_master_pkg::*;

`ifdef APB_TIMEOUT_EN
   localparam int TO    = 8;
   localparam bit TO_EN = 1'b1;
`else
   localparam int TO    = 1024;
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_wr;
   logic [1:0]  cmd_psel;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;

   apb_master_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(2)) bus ();

   apb_master #(.ADDR_W(32), .DATA_W(32), .SEL_W(2), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_psel(cmd_psel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout), .bus(bus)
   );

   always #5 clk = ~clk;

   // Slave model: answers after cfg_waits wait states; random noise outside ACCESS.
   int          cfg_waits = 0;
   logic [31:0] cfg_prd   = '0;
   logic        cfg_perr  = 1'b0;
   logic        noise_en  = 1'b0;
   logic        noise     = 1'b0;
   int          acc_cnt   = 0;

   always @(posedge clk) begin
      acc_cnt <= (bus.pen && !bus.pready) ? acc_cnt + 1 : 0;
      noise   <= 1'($urandom % 2);
   end

   assign bus.pready  = bus.pen ? (acc_cnt >= cfg_waits) : (noise_en & noise);
   assign bus.pslverr = bus.pen ? cfg_perr : (noise_en & noise);
   assign bus.prdata  = cfg_prd;

   typedef struct {
      logic        wr;
      logic [1:0]  sel;
      logic [31:0] addr, wdata;
      int          waits;
      logic [31:0] prd;
      logic        perr;
      int          lat, n_sel, n_en;
      logic        err, to;
      logic [31:0] rdata;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic [1:0] sel, input logic [31:0] addr,
                               input logic [31:0] wdata, input int waits, input logic [31:0] prd,
                               input logic perr, input int lat, input int n_sel, input int n_en,
                               input logic err, input logic [31:0] rdata);
      vec_t v;
      v.wr = wr; v.sel = sel; v.addr = addr; v.wdata = wdata; v.waits = waits;
      v.prd = prd; v.perr = perr; v.lat = lat; v.n_sel = n_sel; v.n_en = n_en;
      v.err = err; v.to = 1'b0; v.rdata = rdata;
      return v;
   endfunction

   // Reference: outcome of one command derived from the protocol rules alone.
   function automatic vec_t model(input vec_t c);
      vec_t v = c;
      if ($countones(c.sel) != 1) begin
         v.lat = 1; v.n_sel = 0; v.n_en = 0; v.err = 1'b1; v.to = 1'b0; v.rdata = '0;
      end else if (TO_EN && c.waits >= TO) begin
         v.lat = 2 + TO; v.n_sel = TO + 1; v.n_en = TO; v.err = 1'b1; v.to = 1'b1; v.rdata = '0;
      end else begin
         v.lat = 3 + c.waits; v.n_sel = c.waits + 2; v.n_en = c.waits + 1;
         v.err = c.perr; v.to = 1'b0; v.rdata = c.wr ? 32'h0 : c.prd;
      end
      return v;
   endfunction

   // Issues one command at the current negedge and watches the bus until the response.
   task automatic run_check(input string tag, input vec_t v);
      int lat = -1, n_sel = 0, n_en = 0;
      logic stable = 1'b1, err = 1'b0, to = 1'b0;
      logic [31:0] rdata = '0;
      cfg_waits = v.waits; cfg_prd = v.prd; cfg_perr = v.perr;
      cmd_valid = 1'b1; cmd_wr = v.wr; cmd_psel = v.sel; cmd_addr = v.addr; cmd_wdata = v.wdata;
      check({tag, "_ready"}, cmd_ready, 1);
      for (int k = 1; k <= 300 && lat < 0; k++) begin
         @(negedge clk);
         if (k == 1) begin
            cmd_valid = 1'b0; cmd_wr = ~v.wr; cmd_psel = ~v.sel;
            cmd_addr = $urandom; cmd_wdata = $urandom;
         end
         if (bus.psel != 2'b00) begin
            n_sel++;
            if (bus.psel != v.sel || bus.pAdd != v.addr || bus.pwr != v.wr ||
                bus.pwData != (v.wr ? v.wdata : 32'h0) || (n_sel == 1 && bus.pen))
               stable = 1'b0;
         end
         if (bus.pen) begin
            n_en++;
            if (bus.psel == 2'b00) stable = 1'b0;
         end
         if (rsp_valid) begin
            lat = k; err = rsp_err; to = rsp_timeout; rdata = rsp_rdata;
         end
      end
      check({tag, "_latency"}, 64'(lat), 64'(v.lat));
      check({tag, "_psel_cycles"}, 64'(n_sel), 64'(v.n_sel));
      check({tag, "_pen_cycles"}, 64'(n_en), 64'(v.n_en));
      check({tag, "_bus_stable"}, stable, 1);
      check({tag, "_err"}, err, v.err);
      check({tag, "_timeout"}, to, v.to);
      if ($countones(v.sel) == 1) check({tag, "_rdata"}, rdata, v.rdata);
   endtask

   vec_t tbl[6];

   initial begin
      vec_t v;
      int   r;
      logic seen;

      tbl[0] = mk(1, PSEL_UART, 32'h4,  32'hA5A51234, 0, 32'h0,        0, 3, 2, 1, 0, 32'h0);
      tbl[1] = mk(0, PSEL_UART, 32'h8,  32'h0,        0, 32'h12345678, 1, 3, 2, 1, 1, 32'h12345678);
      tbl[2] = mk(0, 2'b11,     32'hC,  32'h0,        0, 32'h0,        0, 1, 0, 0, 1, 32'h0);
      tbl[3] = mk(1, 2'b00,     32'h10, 32'h1,        0, 32'h0,        0, 1, 0, 0, 1, 32'h0);
      tbl[4] = mk(1, PSEL_GPIO, 32'h14, 32'h0F0F0F0F, 1, 32'h55AA55AA, 1, 4, 3, 2, 1, 32'h0);
      tbl[5] = mk(0, PSEL_GPIO, 32'h18, 32'h0,        3, 32'hDEADBEEF, 0, 6, 5, 4, 0, 32'hDEADBEEF);

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_psel = '0; cmd_addr = '0; cmd_wdata = '0;
      repeat (3) @(negedge clk);
      check("reset_cmd_ready", cmd_ready, 1);
      check("reset_outputs", {bus.psel, bus.pen, bus.pwr, rsp_valid, rsp_err, rsp_timeout}, 0);
      check("reset_data", {bus.pAdd, bus.pwData, rsp_rdata}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Back-to-back: each command is issued in the previous response cycle.
      for (int i = 0; i < 6; i++) run_check($sformatf("tbl%0d", i), tbl[i]);

      repeat (3) @(negedge clk);
      check("rdata_held", rsp_rdata, 32'hDEADBEEF);
      check("rsp_single_pulse", rsp_valid, 0);

      // Reset during ACCESS: bus drops at once and the transfer never responds.
      cfg_waits = 5; cfg_prd = 32'h1; cfg_perr = 1'b0;
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_psel = PSEL_UART; cmd_addr = 32'h40; cmd_wdata = 32'h77;
      @(negedge clk); cmd_valid = 1'b0;
      @(negedge clk);
      check("midrst_in_access", bus.pen, 1);
      #1 rst_n = 1'b0;
      #1 check("midrst_bus_drop", {bus.psel, bus.pen, bus.pwr}, 0);
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      check("midrst_no_rsp", seen, 0);
      check("midrst_ready", cmd_ready, 1);

      noise_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         r = int'($urandom % 8);
         v.wr = 1'($urandom % 2);
         v.sel = (r < 3) ? PSEL_GPIO : (r < 6) ? PSEL_UART : (r == 6) ? 2'b11 : 2'b00;
         v.addr = $urandom; v.wdata = $urandom; v.prd = $urandom;
         v.waits = int'($urandom % 5); v.perr = ($urandom % 4 == 0);
         v = model(v);
         repeat ($urandom % 3) @(negedge clk);
         run_check($sformatf("rnd%0d", i), v);
      end
      noise_en = 1'b0;

`ifdef APB_TIMEOUT_EN
      v = mk(0, PSEL_GPIO, 32'h80, 32'h0, 1000000, 32'hCAFEF00D, 0, 0, 0, 0, 0, 32'h0);
      run_check("timeout", model(v));
      v = mk(0, PSEL_UART, 32'h84, 32'h0, TO - 1, 32'hCAFEF00D, 0, 0, 0, 0, 0, 32'h0);
      run_check("timeout_edge_win", model(v));
`else
      cfg_waits = 1000000; cfg_prd = 32'h0; cfg_perr = 1'b0;
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_psel = PSEL_GPIO; cmd_addr = 32'h80;
      @(negedge clk); cmd_valid = 1'b0;
      seen = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      check("stuck_pen_high", bus.pen, 1);
      check("stuck_no_rsp", seen, 0);
      cfg_waits = 0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            seen = 1'b1;
            check("stuck_release_timeout", rsp_timeout, 0);
         end
      end
      check("stuck_release_rsp", seen, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
